// File: rtl/antitheft_pkg.sv
// Shared definitions for the anti-theft arming controller.
// Holds the state encoding, the default timer lengths (in 1 Hz ticks),
// the countdown counter width and a helper that names the timed states.
package antitheft_pkg;

    localparam int unsigned CNT_W = 5;

    localparam int unsigned T_ARM_DEF       = 6;
    localparam int unsigned T_DRIVER_DEF    = 8;
    localparam int unsigned T_PASSENGER_DEF = 15;
    localparam int unsigned T_ALARM_DEF     = 10;

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ARMED     = 3'd0,
        TRIGGERED = 3'd1,
        ALARM     = 3'd2,
        DISARMED  = 3'd3,
        IGN_OFF   = 3'd4,
        DOOR_OPEN = 3'd5,
        ARM_DELAY = 3'd6
    } state_t;

    // States whose exit depends on the countdown timer.
    function automatic logic is_timed(input state_t s);
        return (s == TRIGGERED) || (s == ALARM) || (s == ARM_DELAY);
    endfunction

endpackage

// File: rtl/countdown_timer.sv
// Loadable tick countdown used by the anti-theft FSM.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (count clears to 0)
//   load      - load load_val this cycle (takes priority over tick)
//   load_val  - value to load
//   tick      - decrement enable; the count saturates at 0
//   expire    - combinational: tick is high while the count is 1, i.e. the
//               edge that completes the N-th tick after loading N
module countdown_timer
    import antitheft_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = tick && (cnt == W'(1));

endmodule

// File: rtl/antitheft_fsm.sv
// Anti-theft arming controller feeding the fuel-pump cutoff stage.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (state -> ARMED)
//   tick_1hz     - single-cycle pulse once per second
//   ignition     - ignition key on
//   door_driver  - driver door open
//   door_pass    - passenger door open
//   fuel_en      - 1 only while DISARMED (to pump hidden_switch)
//   siren        - 1 only while in ALARM
//   status_led   - toggles per tick in ARMED, 1 in TRIGGERED/ALARM, else 0
//   state_o      - current state encoding
// Outputs are registered from the next state so they change on the same
// edge as state_o.
module antitheft_fsm
    import antitheft_pkg::*;
#(
    parameter int unsigned T_ARM       = T_ARM_DEF,
    parameter int unsigned T_DRIVER    = T_DRIVER_DEF,
    parameter int unsigned T_PASSENGER = T_PASSENGER_DEF,
    parameter int unsigned T_ALARM     = T_ALARM_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    output logic       fuel_en,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_o
);

    state_t             state;
    state_t             state_next;
    logic               load;
    logic [CNT_W-1:0]   load_val;
    logic               expire;
    logic               timer_tick;

    // Ticks outside the timed states are ignored so a leftover count holds.
    assign timer_tick = tick_1hz && is_timed(state);

    countdown_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .tick     (timer_tick),
        .expire   (expire)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_val   = '0;
        case (state)
            ARMED: begin
                // Driver door is checked first so it wins when both open.
                if (door_driver) begin
                    state_next = TRIGGERED;
                    load       = 1'b1;
                    load_val   = CNT_W'(T_DRIVER);
                end else if (door_pass) begin
                    state_next = TRIGGERED;
                    load       = 1'b1;
                    load_val   = CNT_W'(T_PASSENGER);
                end
            end
            TRIGGERED: begin
                if (ignition) begin
                    state_next = DISARMED;
                end else if (expire) begin
                    state_next = ALARM;
                    load       = 1'b1;
                    load_val   = CNT_W'(T_ALARM);
                end
            end
            ALARM: begin
                if (ignition) begin
                    state_next = DISARMED;
                end else if (door_driver || door_pass) begin
                    // Siren hold time restarts while any door is open.
                    load     = 1'b1;
                    load_val = CNT_W'(T_ALARM);
                end else if (expire) begin
                    state_next = ARMED;
                end
            end
            DISARMED: begin
                if (!ignition) begin
                    state_next = IGN_OFF;
                end
            end
            IGN_OFF: begin
                if (ignition) begin
                    state_next = DISARMED;
                end else if (door_driver) begin
                    state_next = DOOR_OPEN;
                end
            end
            DOOR_OPEN: begin
                if (ignition) begin
                    state_next = DISARMED;
                end else if (!door_driver) begin
                    state_next = ARM_DELAY;
                    load       = 1'b1;
                    load_val   = CNT_W'(T_ARM);
                end
            end
            ARM_DELAY: begin
                if (ignition) begin
                    state_next = DISARMED;
                end else if (door_driver) begin
                    state_next = DOOR_OPEN;
                end else if (expire) begin
                    state_next = ARMED;
                end
            end
            default: state_next = ARMED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARMED;
            fuel_en    <= 1'b0;
            siren      <= 1'b0;
            status_led <= 1'b0;
        end else begin
            state   <= state_next;
            fuel_en <= (state_next == DISARMED);
            siren   <= (state_next == ALARM);
            case (state_next)
                // Entering ARMED clears the LED; staying toggles it per tick.
                ARMED:            status_led <= (state == ARMED) ? (status_led ^ tick_1hz) : 1'b0;
                TRIGGERED, ALARM: status_led <= 1'b1;
                default:          status_led <= 1'b0;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_antitheft_fsm.sv
module tb_antitheft_fsm;

    localparam int unsigned TA  = 2;
    localparam int unsigned TD  = 3;
    localparam int unsigned TP  = 5;
    localparam int unsigned TAL = 2;

    localparam int S_ARMED = 0, S_TRIG = 1, S_ALARM = 2, S_DIS = 3;
    localparam int S_IGNOFF = 4, S_DOOR = 5, S_DELAY = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       ignition = 1'b0;
    logic       door_driver = 1'b0;
    logic       door_pass = 1'b0;
    logic       fuel_en;
    logic       siren;
    logic       status_led;
    logic [2:0] state_o;

    antitheft_fsm #(
        .T_ARM       (TA),
        .T_DRIVER    (TD),
        .T_PASSENGER (TP),
        .T_ALARM     (TAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .ignition    (ignition),
        .door_driver (door_driver),
        .door_pass   (door_pass),
        .fuel_en     (fuel_en),
        .siren       (siren),
        .status_led  (status_led),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: state, ticks elapsed since entering a timed state,
    // and the tick limit for that state.
    int   m_st = S_ARMED;
    int   m_since = 0;
    int   m_lim = 0;
    logic m_led = 1'b0;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic enter_timed(input int st, input int unsigned lim);
        m_st    = st;
        m_since = 0;
        m_lim   = int'(lim);
    endtask

    task automatic model_edge();
        logic done;
        done = tick_1hz && (m_since + 1 == m_lim);
        if (rst) begin
            m_st = S_ARMED; m_since = 0; m_lim = 0; m_led = 1'b0;
        end else begin
            case (m_st)
                S_ARMED: begin
                    if (door_driver)    enter_timed(S_TRIG, TD);
                    else if (door_pass) enter_timed(S_TRIG, TP);
                    else if (tick_1hz)  m_led = ~m_led;
                end
                S_TRIG: begin
                    if (ignition)      m_st = S_DIS;
                    else if (done)     enter_timed(S_ALARM, TAL);
                    else if (tick_1hz) m_since++;
                end
                S_ALARM: begin
                    if (ignition)                      m_st = S_DIS;
                    else if (door_driver || door_pass) m_since = 0;
                    else if (done) begin m_st = S_ARMED; m_led = 1'b0; end
                    else if (tick_1hz)                 m_since++;
                end
                S_DIS: if (!ignition) m_st = S_IGNOFF;
                S_IGNOFF: begin
                    if (ignition)         m_st = S_DIS;
                    else if (door_driver) m_st = S_DOOR;
                end
                S_DOOR: begin
                    if (ignition)          m_st = S_DIS;
                    else if (!door_driver) enter_timed(S_DELAY, TA);
                end
                S_DELAY: begin
                    if (ignition)         m_st = S_DIS;
                    else if (door_driver) m_st = S_DOOR;
                    else if (done) begin m_st = S_ARMED; m_led = 1'b0; end
                    else if (tick_1hz)    m_since++;
                end
                default: m_st = S_ARMED;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic t, input logic i, input logic d,
                        input logic p);
        logic exp_led;
        rst = r; tick_1hz = t; ignition = i; door_driver = d; door_pass = p;
        @(posedge clk);
        model_edge();
        #1;
        exp_led = (m_st == S_ARMED) ? m_led : ((m_st == S_TRIG) || (m_st == S_ALARM));
        chk("state", state_o, m_st[2:0]);
        chk("fuel_en", {2'b0, fuel_en}, {2'b0, m_st == S_DIS});
        chk("siren", {2'b0, siren}, {2'b0, m_st == S_ALARM});
        chk("status_led", {2'b0, status_led}, {2'b0, exp_led});
    endtask

    logic ign_r = 1'b0, dd_r = 1'b0, dp_r = 1'b0;

    initial begin
        // 1: driver door pulse, alarm on third tick
        step(1, 0, 0, 0, 0);
        chk("rst_state", state_o, 3'd0);
        chk("rst_outs", {fuel_en, siren, status_led}, 3'b000);
        step(0, 0, 0, 1, 0);
        chk("s1_trig", state_o, 3'd1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("s1_pre", state_o, 3'd1);
        step(0, 1, 0, 0, 0);
        chk("s1_alarm", state_o, 3'd2);
        chk("s1_outs", {fuel_en, siren}, 2'b01);

        // 3: door held through 5 ticks keeps alarm, then 2 ticks after close
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 1);
            step(0, 0, 0, 0, 1);
        end
        chk("s3_hold", state_o, 3'd2);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("s3_siren", {2'b0, siren}, 3'd1);
        step(0, 1, 0, 0, 0);
        chk("s3_armed", state_o, 3'd0);
        chk("s3_outs", {siren, status_led}, 2'b00);

        // 2: passenger trigger, ignition after 4 ticks
        step(0, 0, 0, 0, 1);
        chk("s2_trig", state_o, 3'd1);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0);
        chk("s2_pre", state_o, 3'd1);
        step(0, 0, 1, 0, 0);
        chk("s2_dis", state_o, 3'd3);
        chk("s2_outs", {fuel_en, siren}, 2'b10);

        // 4: exit sequence with a reopen during arm delay
        step(0, 0, 0, 0, 0); chk("s4_ignoff", state_o, 3'd4);
        step(0, 0, 0, 1, 0); chk("s4_door", state_o, 3'd5);
        step(0, 0, 0, 0, 0); chk("s4_delay", state_o, 3'd6);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0); chk("s4_reopen", state_o, 3'd5);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0); chk("s4_wait", state_o, 3'd6);
        step(0, 1, 0, 0, 0); chk("s4_armed", state_o, 3'd0);
        chk("s4_fuel", {2'b0, fuel_en}, 3'd0);

        // LED toggling while armed
        step(0, 1, 0, 0, 0); chk("led_on", {2'b0, status_led}, 3'd1);
        step(0, 1, 0, 0, 0); chk("led_off", {2'b0, status_led}, 3'd0);

        // 5: ignition on the expiry tick wins
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("s5_dis", state_o, 3'd3);
        chk("s5_siren", {2'b0, siren}, 3'd0);

        // 6: reset during alarm
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        chk("s6_alarm", state_o, 3'd2);
        step(1, 0, 0, 0, 0);
        chk("s6_state", state_o, 3'd0);
        chk("s6_outs", {fuel_en, siren, status_led}, 3'b000);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) ign_r = ~ign_r;
            if ($urandom_range(0, 5) == 0)  dd_r  = ~dd_r;
            if ($urandom_range(0, 5) == 0)  dp_r  = ~dp_r;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, ign_r, dd_r, dp_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
